imem_dport_arbiter: RTL and testbench

Shares the data-side (D) read port of the dual-port instruction block RAM between two requesters: the CPU data path (LD/LDR reads of code space) and the debug/boot monitor. The CPU has fixed priority, and a starvation counter guarantees the debug requester a slot. The block sits between both requesters and the memory's En_D/Addr_D/Data_D port. The I port is untouched.

---
 rtl/imem_arb_pkg.sv | 13 +
 rtl/arb_starve_counter.sv | 29 ++
 rtl/imem_dport_arbiter.sv | 105 ++++++++++
 tb/tb_imem_dport_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and constants for the instruction RAM D-port arbiter
package imem_arb_pkg;

    // Owner of the read issued in the previous cycle, i.e. who gets the returning data
    typedef enum logic [1:0] {
        RT_NONE = 2'd0,
        RT_CPU  = 2'd1,
        RT_DBG  = 2'd2
    } rt_state_e;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating wait counter for the debug requester
module arb_starve_counter
    import imem_arb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  at_limit
);

    localparam logic [WAIT_CNT_W-1:0] LIM = WAIT_CNT_W'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count < LIM)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/imem_dport_arbiter.sv
// rtl/imem_dport_arbiter.sv - CPU/debug arbiter for the instruction RAM D read port
// Optional out-of-range check: IMEM_ARB_RANGE_CHK_EN
module imem_dport_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 29,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MEM_WORDS    = 256
) (
    input  logic                  Clock,
    input  logic                  SysReset,
    input  logic                  CpuReq,
    input  logic [ADDR_WIDTH-1:0] CpuAddr,
    output logic                  CpuStall,
    output logic                  CpuValid,
    output logic [DATA_WIDTH-1:0] CpuData,
    input  logic                  DbgReq,
    input  logic [ADDR_WIDTH-1:0] DbgAddr,
    output logic                  DbgValid,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic                  AddrErr,
    output logic                  En_D,
    output logic [ADDR_WIDTH-1:0] Addr_D,
    input  logic [DATA_WIDTH-1:0] Data_D
);

    rt_state_e              state;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic                   at_limit;
    logic                   active;
    logic                   dbg_ok;
    logic                   force_dbg;
    logic                   dbg_win;
    logic                   cpu_win;
    logic                   issue;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic                   out_of_range;

    // Grants are suppressed combinationally while reset is held so En_D stays low
    assign active    = SysReset;
    assign dbg_ok    = DbgReq && (state != RT_DBG);
    assign force_dbg = dbg_ok && at_limit;
    assign dbg_win   = active && (force_dbg || (dbg_ok && !CpuReq));
    assign cpu_win   = active && CpuReq && !force_dbg;
    assign issue     = dbg_win || cpu_win;
    assign win_addr  = dbg_win ? DbgAddr : (cpu_win ? CpuAddr : '0);
    assign CpuStall  = active && force_dbg && CpuReq;
    assign Addr_D    = win_addr;

    assign out_of_range = issue && (win_addr >= ADDR_WIDTH'(MEM_WORDS));

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (Clock),
        .rst_n    (SysReset),
        .clear    (dbg_win),
        .inc      (dbg_ok && cpu_win),
        .count    (wait_cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge Clock or negedge SysReset) begin
        if (!SysReset) begin
            state <= RT_NONE;
        end else if (dbg_win) begin
            state <= RT_DBG;
        end else if (cpu_win) begin
            state <= RT_CPU;
        end else begin
            state <= RT_NONE;
        end
    end

    assign CpuValid = (state == RT_CPU);
    assign DbgValid = (state == RT_DBG);

`ifdef IMEM_ARB_RANGE_CHK_EN
    logic err_q;

    // Error bit travels with the return tag; the owner still gets a valid, with zeroed data
    always_ff @(posedge Clock or negedge SysReset) begin
        if (!SysReset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= out_of_range;
        end
    end

    assign En_D    = issue && !out_of_range;
    assign AddrErr = err_q;
    assign CpuData = (err_q && (state == RT_CPU)) ? '0 : Data_D;
    assign DbgData = (err_q && (state == RT_DBG)) ? '0 : Data_D;
`else
    logic unused_range;

    assign unused_range = out_of_range;
    assign En_D         = issue;
    assign AddrErr      = 1'b0;
    assign CpuData      = Data_D;
    assign DbgData      = Data_D;
`endif

endmodule

// File: tb/tb_imem_dport_arbiter.sv
// tb/tb_imem_dport_arbiter.sv - directed scoreboard bench for imem_dport_arbiter
module tb_imem_dport_arbiter;

    localparam int AW = 29;
    localparam int DW = 32;

    logic          Clock;
    logic          SysReset;
    logic          CpuReq;
    logic [AW-1:0] CpuAddr;
    logic          CpuStall;
    logic          CpuValid;
    logic [DW-1:0] CpuData;
    logic          DbgReq;
    logic [AW-1:0] DbgAddr;
    logic          DbgValid;
    logic [DW-1:0] DbgData;
    logic          AddrErr;
    logic          En_D;
    logic [AW-1:0] Addr_D;
    logic [DW-1:0] Data_D;

    int total = 0;
    int bad   = 0;

    logic [32:0] cpu_q[$];
    logic [32:0] dbg_q[$];
    logic [32:0] cpu_e;
    logic [32:0] dbg_e;

    imem_dport_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (8),
        .MEM_WORDS    (256)
    ) dut (
        .Clock    (Clock),
        .SysReset (SysReset),
        .CpuReq   (CpuReq),
        .CpuAddr  (CpuAddr),
        .CpuStall (CpuStall),
        .CpuValid (CpuValid),
        .CpuData  (CpuData),
        .DbgReq   (DbgReq),
        .DbgAddr  (DbgAddr),
        .DbgValid (DbgValid),
        .DbgData  (DbgData),
        .AddrErr  (AddrErr),
        .En_D     (En_D),
        .Addr_D   (Addr_D),
        .Data_D   (Data_D)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous-read RAM, latency 1
    always @(posedge Clock) begin
        if (En_D) Data_D <= mem_word(Addr_D);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue_chk(input string tag, input logic en, input logic [AW-1:0] a,
                             input logic st);
        #2;
        chk({tag, "_en"}, 64'(En_D), 64'(en));
        chk({tag, "_addr"}, 64'(Addr_D), 64'(a));
        chk({tag, "_stall"}, 64'(CpuStall), 64'(st));
    endtask

    // Return-side scoreboard, sampled on the falling edge
    always @(negedge Clock) begin
        if (CpuValid) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_spurious", 64'(CpuValid), 64'd0);
            end else begin
                cpu_e = cpu_q.pop_front();
                chk("cpu_ret", 64'({AddrErr, CpuData}), 64'(cpu_e));
            end
        end
        if (DbgValid) begin
            if (dbg_q.size() == 0) begin
                chk("dbg_spurious", 64'(DbgValid), 64'd0);
            end else begin
                dbg_e = dbg_q.pop_front();
                chk("dbg_ret", 64'({AddrErr, DbgData}), 64'(dbg_e));
            end
        end
        if (!CpuValid && !DbgValid) chk("err_idle", 64'(AddrErr), 64'd0);
    end

    initial begin
        SysReset = 1'b0;
        CpuReq   = 1'b1;
        CpuAddr  = 29'h5;
        DbgReq   = 1'b1;
        DbgAddr  = 29'h7;

        // Reset state with requests asserted
        #3;
        issue_chk("rst", 1'b0, '0, 1'b0);
        chk("rst_cvalid", 64'(CpuValid), 64'd0);
        chk("rst_dvalid", 64'(DbgValid), 64'd0);
        chk("rst_err", 64'(AddrErr), 64'd0);
        next();
        CpuReq = 1'b0;
        DbgReq = 1'b0;
        next();
        SysReset = 1'b1;
        issue_chk("idle0", 1'b0, '0, 1'b0);

        // Single CPU read
        next();
        CpuReq  = 1'b1;
        CpuAddr = 29'h10;
        cpu_q.push_back({1'b0, mem_word(29'h10)});
        issue_chk("cpu1", 1'b1, 29'h10, 1'b0);
        next();
        CpuReq = 1'b0;
        issue_chk("cpu1_ret", 1'b0, '0, 1'b0);
        chk("cpu1_cvalid", 64'(CpuValid), 64'd1);
        chk("cpu1_dvalid", 64'(DbgValid), 64'd0);

        // Debug alone, held high across its return cycle
        next();
        DbgReq  = 1'b1;
        DbgAddr = 29'h20;
        dbg_q.push_back({1'b0, mem_word(29'h20)});
        issue_chk("dbg1", 1'b1, 29'h20, 1'b0);
        next();
        issue_chk("dbg1_gap", 1'b0, '0, 1'b0);
        chk("dbg1_dvalid", 64'(DbgValid), 64'd1);
        next();
        dbg_q.push_back({1'b0, mem_word(29'h20)});
        issue_chk("dbg2", 1'b1, 29'h20, 1'b0);
        next();
        DbgReq = 1'b0;
        issue_chk("dbg2_ret", 1'b0, '0, 1'b0);
        chk("dbg2_dvalid", 64'(DbgValid), 64'd1);
        next();
        issue_chk("idle1", 1'b0, '0, 1'b0);

        // Starvation: two rounds of 8 CPU wins, forced debug, held CPU served
        DbgAddr = 29'h30;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                next();
                CpuReq  = 1'b1;
                DbgReq  = 1'b1;
                CpuAddr = 29'h40 + AW'(r * 16 + i);
                cpu_q.push_back({1'b0, mem_word(CpuAddr)});
                issue_chk("starve_cpu", 1'b1, CpuAddr, 1'b0);
            end
            next();
            CpuAddr = 29'h40 + AW'(r * 16 + 8);
            dbg_q.push_back({1'b0, mem_word(29'h30)});
            issue_chk("starve_force", 1'b1, 29'h30, 1'b1);
            next();
            cpu_q.push_back({1'b0, mem_word(CpuAddr)});
            issue_chk("starve_held", 1'b1, CpuAddr, 1'b0);
        end
        next();
        CpuReq = 1'b0;
        DbgReq = 1'b0;
        issue_chk("idle2", 1'b0, '0, 1'b0);
        next();

        // Reset asserted in the cycle after a CPU issue discards the read
        next();
        CpuReq  = 1'b1;
        CpuAddr = 29'h55;
        issue_chk("rst_fl", 1'b1, 29'h55, 1'b0);
        next();
        CpuReq   = 1'b0;
        SysReset = 1'b0;
        issue_chk("rst_fl_in", 1'b0, '0, 1'b0);
        chk("rst_fl_cvalid", 64'(CpuValid), 64'd0);
        next();
        next();
        SysReset = 1'b1;
        issue_chk("rst_rel", 1'b0, '0, 1'b0);
        chk("rst_rel_cvalid", 64'(CpuValid), 64'd0);
        chk("rst_rel_dvalid", 64'(DbgValid), 64'd0);
        next();
        issue_chk("rst_rel2", 1'b0, '0, 1'b0);
        chk("rst_rel2_cvalid", 64'(CpuValid), 64'd0);

        // Address at MEM_WORDS
        next();
        CpuReq  = 1'b1;
        CpuAddr = 29'h100;
`ifdef IMEM_ARB_RANGE_CHK_EN
        cpu_q.push_back({1'b1, 32'h0});
        issue_chk("range", 1'b0, 29'h100, 1'b0);
`else
        cpu_q.push_back({1'b0, mem_word(29'h100)});
        issue_chk("range", 1'b1, 29'h100, 1'b0);
`endif
        next();
        CpuReq = 1'b0;
        #2;
        chk("range_cvalid", 64'(CpuValid), 64'd1);
`ifdef IMEM_ARB_RANGE_CHK_EN
        chk("range_err", 64'(AddrErr), 64'd1);
        chk("range_data", 64'(CpuData), 64'd0);
`else
        chk("range_err", 64'(AddrErr), 64'd0);
`endif
        next();
        next();

        chk("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        chk("dbg_q_drained", 64'(dbg_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
